// File: rtl/vga_pkg.sv
// ============================================================================
// vga_pkg: 640x480@60 timing constants and widths shared by the display path
// Rev 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int CLK_DIV  = 4;

    localparam int CNT_W    = 10;
    localparam int COLOR_W  = 12;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;

    localparam logic [COLOR_W-1:0] BLACK = 12'h000;

    // Inclusive window test used for both sync pulses.
    function automatic logic in_window(input logic [CNT_W-1:0] val,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_scan_wrap_counter.sv
// ============================================================================
// wrap_counter: enabled modulo-MOD counter with a single-cycle wrap strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module wrap_counter #(
    parameter int MOD = 4,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    // Wrap is qualified by enable so it can chain directly into the next stage.
    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_scan.sv
// ============================================================================
// vga_scan: VGA scan generator with registered, blanked RGB444 and sync outputs
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_scan
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int CLK_DIV  = vga_pkg::CLK_DIV
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COLOR_W-1:0] color,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic               active,
    output logic [3:0]         r,
    output logic [3:0]         g,
    output logic [3:0]         b,
    output logic               hs,
    output logic               vs,
    output logic               frame_tick
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic               div_wrap;
    logic               pix_en;
    logic [CNT_W-1:0]   h_cnt;
    logic               h_wrap;
    logic [CNT_W-1:0]   v_cnt;
    logic               v_wrap;
    logic [COLOR_W-1:0] rgb_reg;

    wrap_counter #(.MOD(CLK_DIV), .W(DIV_W)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .cnt   (div_cnt),
        .wrap  (div_wrap)
    );

    // The divider is free-running, so both terms are equivalent; the count
    // compare keeps the pixel phase explicit.
    assign pix_en = div_wrap && (div_cnt == DIV_LAST);

    wrap_counter #(.MOD(H_TOT), .W(CNT_W)) u_h (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_en),
        .cnt   (h_cnt),
        .wrap  (h_wrap)
    );

    wrap_counter #(.MOD(V_TOT), .W(CNT_W)) u_v (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (h_wrap),
        .cnt   (v_cnt),
        .wrap  (v_wrap)
    );

    assign x      = h_cnt[X_W-1:0];
    assign y      = v_cnt[Y_W-1:0];
    assign active = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);

    // Colour and syncs are registered on the same pix_en so they share one lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_reg <= BLACK;
            hs      <= 1'b1;
            vs      <= 1'b1;
        end else if (pix_en) begin
            rgb_reg <= active ? color : BLACK;
            hs      <= ~in_window(h_cnt, HS_START, HS_END);
            vs      <= ~in_window(v_cnt, VS_START, VS_END);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= v_wrap;
        end
    end

    assign r = rgb_reg[11:8];
    assign g = rgb_reg[7:4];
    assign b = rgb_reg[3:0];

endmodule

`default_nettype wire

// File: doc/vga_scan.md
# vga_scan

VGA 640x480@60 scan generator and pixel output stage for the display path. It generates the `x`/`y` pixel coordinates consumed by the screen colour generators (welcome background, game screens), samples their 12-bit `color` result once per pixel, and drives the registered, blanked RGB444 and sync outputs to the VGA connector. One instance sits at the top level between the screen multiplexer and the board pins.

## Interface
- `H_ACTIVE`, default 640: visible pixels per line.
- `H_FP`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: hsync pulse width, in pixels.
- `H_BP`, default 48: horizontal back porch, in pixels; line total is 800.
- `V_ACTIVE`, default 480: visible lines per frame.
- `V_FP`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vsync pulse width, in lines.
- `V_BP`, default 33: vertical back porch, in lines; frame total is 525.
- `CLK_DIV`, default 4: system clocks per pixel; must be ≥2. 100 MHz / 4 = 25 MHz pixel rate.

Ports:
- `clk`, input, 1 bit: system clock. One clock domain; all state changes on its rising edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `color`, input, 12 bits: pixel colour {R[3:0], G[3:0], B[3:0]} for the current `x`/`y`.
- `x`, output, 10 bits: current horizontal count, truncated. Meaningful only while `active`.
- `y`, output, 9 bits: current vertical count, truncated. Meaningful only while `active`.
- `active`, output, 1 bit: high when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- `r`, `g`, `b`, output, 4 bits each: registered colour to the DAC.
- `hs`, `vs`, output, 1 bit each: registered syncs, active low.
- `frame_tick`, output, 1 bit: one-`clk` pulse at each frame wrap.

## Operation
- Divider `div`:
  - Counts 0..CLK_DIV-1 and wraps.
  - `pix_en` = (div == CLK_DIV-1).
- Horizontal counter `h_cnt` (10 bits):
  - Advances only on `pix_en`, counting 0..799.
  - Wraps to 0 after 799.
- Vertical counter `v_cnt` (10 bits):
  - Advances on `pix_en` when `h_cnt` == 799, counting 0..524.
  - Wraps to 0 after 524.
- `x` = h_cnt[9:0] and `y` = v_cnt[8:0], driven combinationally from the counter registers.
- `active` is combinational from the counters; no extra register.
- Output stage, updated on `pix_en` only:
  - rgb ← active ? color : 12'h000.
  - hs ← ~(656 ≤ h_cnt ≤ 751).
  - vs ← ~(490 ≤ v_cnt ≤ 491).
  - Result: RGB and syncs share one common one-pixel lag relative to the counters, so they stay mutually aligned.
- `frame_tick` = `pix_en` & (h_cnt == 799) & (v_cnt == 524), registered. It goes high for one `clk` on the cycle after that edge, i.e. when the counters read (0,0).
- Sync boundaries are derived from the parameters, never hard-coded: sync starts at ACTIVE+FP and ends at ACTIVE+FP+SYNC-1.

## Timing
- Reset values (while `rst_n` = 0, immediately):
  - div=0, h_cnt=0, v_cnt=0, so x=0, y=0, active=1.
  - r=g=b=0, hs=1, vs=1, frame_tick=0.
- Reset released mid-frame restarts the scan at pixel (0,0) on the first clk. No partial-line sync is emitted.
- `x`/`y` change on the `pix_en` edge and stay stable for CLK_DIV clks.
- `color` is sampled at the next `pix_en` edge, CLK_DIV clks after `x`/`y` changed. Upstream ROM plus priority-mux latency must be ≤ CLK_DIV-1 clks (3 at default).
- Pixel rate: 1 pixel per CLK_DIV clks.
- Line period: 800×CLK_DIV = 3200 clks.
- Frame period: 525 lines = 1,680,000 clks.
- hsync low: 96 pixels = 384 clks.
- vsync low: 2 lines = 6400 clks.

## Structure
- Shared package `vga_pkg` holds:
  - the timing constants (actives, porches, sync widths, totals);
  - `COLOR_W`=12, `X_W`=10, `Y_W`=9;
  - the black constant 12'h000.
  All screen generators use these same constants.
- One sub-module, `wrap_counter`: parameterised modulus, enable input, wrap output, async active-low reset. It is instanced three times: divider, horizontal, vertical. The horizontal instance's wrap output is the vertical instance's enable.
- The output register stage stays in `vga_scan`.

## Test plan
- Reset: hold `rst_n`=0 and toggle `clk` → x=0, y=0, rgb=0, hs=vs=1, frame_tick=0. Release reset → x becomes 1 exactly 4 clks later.
- Colour pass/blank: drive `color`=12'hF0A constant → r=F, g=0, b=A for output pixels 0..639 of visible lines. rgb=0 for h_cnt 640..799 and for v_cnt ≥ 480.
- Hsync: measure from line start → `hs` falls on the `pix_en` edge where h_cnt=656 and stays low 384 clks. Line period is 3200 clks.
- Vsync and frame tick:
  - vs low for exactly 6400 clks starting at v_cnt=490.
  - frame_tick pulses once per 1,680,000 clks, width 1 clk, coincident with counters reading (0,0).
- Colour latency: drive `color` = {x[3:0], y[3:0], 4'h5} through a 3-clk delay line → output pixel at (x, y) carries its own coordinates, one pixel late, with no smear.
- Reset mid-frame: assert `rst_n` low at h_cnt=300, v_cnt=200 for 2 clks → all outputs return to reset values at once, and the scan restarts from (0,0).
